// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host receiver (sync+filter ps2_clk/ps2_data, 11-bit frame, E0/F0 decode) -> data_out/ready/released/extended/frame_err/busy
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       released,
  output logic       extended,
  output logic       frame_err,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  logic [1:0]    cs, ds, state;
  logic          fclk, fe, brk_flag, ext_flag;
  logic [3:0]    fcnt, cnt;
  logic [10:0]   sr;
  logic [TW-1:0] tcnt;
  logic          sc, sd, ok;
  logic [7:0]    code;
  assign sc   = cs[1];
  assign sd   = ds[1];
  assign code = sr[8:1];
  assign ok   = !sr[0] && sr[10] && ^sr[9:1];
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      cs   <= 2'b11;
      ds   <= 2'b11;
      fclk <= 1'b1;
      fcnt <= '0;
      fe   <= 1'b0;
    end else begin
      cs <= {cs[0], ps2_clk};
      ds <= {ds[0], ps2_data};
      fe <= 1'b0;
      if (sc == fclk) fcnt <= '0;
      else if (fcnt == 4'(FILTER_LEN - 1)) begin
        fclk <= sc;
        fcnt <= '0;
        fe   <= fclk;
      end else fcnt <= fcnt + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      tcnt      <= '0;
      brk_flag  <= 1'b0;
      ext_flag  <= 1'b0;
      data_out  <= '0;
      ready     <= 1'b0;
      released  <= 1'b0;
      extended  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ready     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (fe) begin
            sr    <= {sd, sr[10:1]};
            cnt   <= 4'd1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (fe) begin
            sr    <= {sd, sr[10:1]};
            cnt   <= cnt + 4'd1;
            tcnt  <= '0;
            state <= cnt == 4'd10 ? CHECK : SHIFT;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 2)) begin
            frame_err <= 1'b1;
            brk_flag  <= 1'b0;
            ext_flag  <= 1'b0;
            state     <= IDLE;
          end else tcnt <= tcnt + TW'(1);
        end
        CHECK: begin
          state <= IDLE;
          if (!ok) begin
            frame_err <= 1'b1;
            brk_flag  <= 1'b0;
            ext_flag  <= 1'b0;
          end else if (code == 8'hF0) brk_flag <= 1'b1;
          else if (code == 8'hE0) ext_flag <= 1'b1;
          else begin
            data_out <= code;
            released <= brk_flag;
            extended <= ext_flag;
            ready    <= 1'b1;
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
